univ_shift_reg: RTL
===================

Name: univ_shift_reg

Overview:
- Parametrised universal shift register; successor to the fixed 4-bit serial-in/serial-out shifter.
- Adds configurable width, bidirectional shift, rotate, parallel load and synchronous clear.
- Adds a shift counter with a word-complete pulse, so the block can serialise or deserialise whole words.
- Sits between serial links and parallel datapaths.

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- CW, $clog2(WIDTH+1), shift-counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- clear_n  input  1  synchronous, active-low reset.
- en  input  1  clock enable; 0 = hold all state.
- mode  input  3  operation select (see Behaviour).
- si  input  1  serial data in.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents (registered).
- so_msb  output  1  equals q[WIDTH-1]; combinational tap, no added latency.
- so_lsb  output  1  equals q[0]; combinational tap, no added latency.
- cnt  output  CW  shifts since last load/clear (registered, saturating).
- done  output  1  registered one-cycle pulse when cnt reaches WIDTH.

Behaviour:
- Reset
  - One clock only. Reset is synchronous and active-low: clear_n=0 at a rising edge sets q=0, cnt=0, done=0.
  - Reset has priority over en and mode. Asserting it mid-word aborts the word; no done pulse is issued.
- Enable
  - en=0: q and cnt hold; done<=0.
- Modes (en=1):
  - 000 HOLD: q, cnt unchanged.
  - 001 SHL: q <= {q[WIDTH-2:0], si}; si enters bit 0.
  - 010 SHR: q <= {si, q[WIDTH-1:1]}; si enters bit WIDTH-1.
  - 011 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; si ignored.
  - 100 ROR: q <= {q[0], q[WIDTH-1:1]}; si ignored.
  - 101 LOAD: q <= d; cnt <= 0.
  - 110 CLR: q <= 0; cnt <= 0.
  - 111 reserved: behaves exactly as HOLD.
- Counter
  - Each enabled SHL/SHR/ROL/ROR increments cnt.
  - cnt saturates at WIDTH; further shifts keep cnt=WIDTH and do not pulse done again.
- done
  - done<=1 on the edge where a shift moves cnt from WIDTH-1 to WIDTH; otherwise done<=0.
  - done is therefore high for exactly the one cycle in which cnt first reads WIDTH.
  - Only LOAD, CLR or reset re-arm it by returning cnt to 0.
- Output timing
  - q and cnt are visible the cycle after the edge.
  - so_msb/so_lsb follow q with no further register stage: the first bit of a loaded word is on so_msb/so_lsb in the cycle immediately after LOAD.
- Mode change mid-word (e.g. SHL then SHR) is legal; cnt keeps counting, with no direction tracking.
- No X propagation: si and d are sampled only in modes that use them.

Test Plan:
- Reset / reserved mode / enable gating (WIDTH=8):
  - clear_n=0 for 2 cycles with en=1, mode=101, d=8'hFF -> q=8'h00, cnt=0, done=0 throughout.
  - Release reset, LOAD 8'hA5, then mode=111 for 3 cycles -> q stays 8'hA5, cnt=0.
  - Then en=0 with mode=001 for 3 cycles -> q=8'hA5, done=0.
- SHL deserialise (WIDTH=4):
  - clear, then SHL with si=1,0,1,1 on 4 consecutive edges -> q=4'b1011, cnt=4.
  - done=1 only in the cycle after the 4th edge; a 5th SHL -> cnt stays 4, done=0.
- SHR serialise (WIDTH=8):
  - LOAD 8'hC3, then 8 SHR with si=0 -> so_lsb sequence 1,1,0,0,0,0,1,1 (first bit valid the cycle after LOAD).
  - Final q=8'h00; done pulses once.
- Rotate (WIDTH=8):
  - LOAD 8'h81, then ROL -> 8'h03; then ROR twice -> 8'hC0.
  - cnt=3; si toggled throughout has no effect.
- Reset mid-word (WIDTH=8):
  - LOAD 8'hFF, 5 SHL, then clear_n=0 one cycle -> q=0, cnt=0.
  - Resume 8 SHL -> done pulses exactly once, after the 8th shift.
- CLR / LOAD re-arm:
  - After done at cnt=8, mode=110 -> q=0, cnt=0.
  - Another 8 shifts -> second done pulse.
  - LOAD issued on the cycle cnt would reach 8 -> cnt=0, no done.

Source files
------------

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module   : univ_shift_reg
// Brief    : Universal shift register (shift/rotate/load/clear) with a
//            saturating shift counter and a word-complete pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             si,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             so_msb,
  output logic             so_lsb,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             w_shift;

  always_comb begin
    q_d     = q_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    w_shift = 1'b0;
    case (mode)
      MODE_HOLD: q_d = q_q;
      MODE_SHL: begin
        q_d     = {q_q[WIDTH-2:0], si};
        w_shift = 1'b1;
      end
      MODE_SHR: begin
        q_d     = {si, q_q[WIDTH-1:1]};
        w_shift = 1'b1;
      end
      MODE_ROL: begin
        q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        w_shift = 1'b1;
      end
      MODE_ROR: begin
        q_d     = {q_q[0], q_q[WIDTH-1:1]};
        w_shift = 1'b1;
      end
      MODE_LOAD: begin
        q_d   = d;
        cnt_d = '0;
      end
      MODE_CLR: begin
        q_d   = '0;
        cnt_d = '0;
      end
      default: q_d = q_q;
    endcase
    // Saturation stops the counter at WIDTH so done fires only once per word.
    if (w_shift && (cnt_q != CNT_FULL)) begin
      cnt_d  = cnt_q + CW'(1);
      done_d = (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      q_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (en) begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end else begin
      done_q <= 1'b0;
    end
  end

  assign q      = q_q;
  assign cnt    = cnt_q;
  assign done   = done_q;
  assign so_msb = q_q[WIDTH-1];
  assign so_lsb = q_q[0];

endmodule

`default_nettype wire
